// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: access size encodings and FSM states.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32 loads/stores: store byte enables and data shift, load extension.
// With DMEM_MISALIGN_ERR_EN defined, also flags misaligned half/word accesses.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext
`ifdef DMEM_MISALIGN_ERR_EN
    ,
    output logic        misaligned
`endif
);

    logic [1:0]  off;
    logic [31:0] rshift;

    always_comb begin
        off         = 2'b00;
        byte_en     = 4'b1111;
        wdata_lanes = wdata;
        rdata_ext   = rword;
        rshift      = rword;
        case (size)
            SZ_BYTE: begin
                off         = addr_lo;
                byte_en     = 4'b0001 << off;
                wdata_lanes = {24'b0, wdata[7:0]} << {off, 3'b000};
                rshift      = rword >> {off, 3'b000};
                rdata_ext   = {{24{~uns & rshift[7]}}, rshift[7:0]};
            end
            SZ_HALF: begin
                // low address bit is dropped so a half never straddles lanes
                off         = {addr_lo[1], 1'b0};
                byte_en     = 4'b0011 << off;
                wdata_lanes = {16'b0, wdata[15:0]} << {off, 3'b000};
                rshift      = rword >> {off, 3'b000};
                rdata_ext   = {{16{~uns & rshift[15]}}, rshift[15:0]};
            end
            default: begin
                off         = 2'b00;
                byte_en     = 4'b1111;
                wdata_lanes = wdata;
                rshift      = rword;
                rdata_ext   = rword;
            end
        endcase
    end

`ifdef DMEM_MISALIGN_ERR_EN
    assign misaligned = ((size == SZ_HALF) && addr_lo[0]) || (size[1] && (addr_lo != 2'b00));
`endif

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressed RV32 data memory behind a req/rsp handshake with a programmable wait-state count.
// Optional DMEM_MISALIGN_ERR_EN adds rsp_err and suppresses misaligned half/word accesses.
//   state | meaning
//   IDLE  | req_ready high, request captured on req_valid
//   WAIT  | wait-state countdown; array accessed on the edge where count == 1
//   RESP  | rsp_valid/rsp_rdata presented for one cycle
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1,
    parameter int DATA_W      = 32
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              busy
`ifdef DMEM_MISALIGN_ERR_EN
    ,
    output logic              rsp_err
`endif
);

    localparam int         WORDS     = 2 ** (ADDR_W - 2);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("data_mem_ctrl: DATA_W must be 32");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("data_mem_ctrl: WAIT_CYCLES must be 0..15");
    end

    state_t              state, state_nx;
    logic [3:0]          cnt;
    logic                do_access;
    logic                we_q, uns_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic                a_we, a_uns;
    logic [1:0]          a_size;
    logic [ADDR_W-1:0]   a_addr;
    logic [31:0]         a_wdata;
    logic [ADDR_W-3:0]   a_idx;
    logic [31:0]         rword, wdata_lanes, rdata_ext;
    logic [3:0]          byte_en;
    logic                acc_err;

    // Power-up contents; reset deliberately leaves the array alone.
    logic [31:0] mem [WORDS] = '{0: 32'd1, 1: 32'd5, 2: 32'd25, default: 32'd0};

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        do_access = 1'b1;
                        state_nx  = RESP;
                    end else begin
                        state_nx  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) begin
                    do_access = 1'b1;
                    state_nx  = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Zero-wait accesses happen on the accept edge, so they use the live request.
    assign a_we    = (state == IDLE) ? req_we       : we_q;
    assign a_uns   = (state == IDLE) ? req_unsigned : uns_q;
    assign a_size  = (state == IDLE) ? req_size     : size_q;
    assign a_addr  = (state == IDLE) ? req_addr     : addr_q;
    assign a_wdata = (state == IDLE) ? req_wdata    : wdata_q;
    assign a_idx   = a_addr[ADDR_W-1:2];
    assign rword   = mem[a_idx];
    assign busy    = (state != IDLE);

    dmem_lane_align u_align (
        .size        (a_size),
        .uns         (a_uns),
        .addr_lo     (a_addr[1:0]),
        .wdata       (a_wdata),
        .rword       (rword),
        .byte_en     (byte_en),
        .wdata_lanes (wdata_lanes),
        .rdata_ext   (rdata_ext)
`ifdef DMEM_MISALIGN_ERR_EN
        ,
        .misaligned  (acc_err)
`endif
    );

`ifndef DMEM_MISALIGN_ERR_EN
    assign acc_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
`ifdef DMEM_MISALIGN_ERR_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            rsp_valid <= do_access;
            if (state == IDLE && req_valid) begin
                cnt <= WAIT_INIT;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access) begin
                rsp_rdata <= (a_we || acc_err) ? 32'd0 : rdata_ext;
`ifdef DMEM_MISALIGN_ERR_EN
                rsp_err   <= acc_err;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_access && a_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[a_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: three controllers (WAIT_CYCLES 1, 0, 3) share clock, reset and request fields.
module tb_data_mem_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_valid = 3'b000;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_uns = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [31:0] req_wdata = 32'h0;
    wire  [2:0]  ready, rvalid, bsy;
    wire  [31:0] rdat [3];
`ifdef DMEM_MISALIGN_ERR_EN
    wire  [2:0]  rerr;
`endif
    int tests_run = 0;
    int fails = 0;
    localparam int WC [3] = '{1, 0, 3};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_ctrl #(.ADDR_W(8), .WAIT_CYCLES(WC[g]), .DATA_W(32)) dut (
            .clk          (clk),
            .rst          (rst),
            .req_valid    (req_valid[g]),
            .req_ready    (ready[g]),
            .req_we       (req_we),
            .req_size     (req_size),
            .req_unsigned (req_uns),
            .req_addr     (req_addr),
            .req_wdata    (req_wdata),
            .rsp_valid    (rvalid[g]),
            .rsp_rdata    (rdat[g]),
            .busy         (bsy[g])
`ifdef DMEM_MISALIGN_ERR_EN
            ,
            .rsp_err      (rerr[g])
`endif
        );
    end

    // One request on instance k; inputs are scrambled after accept. lat = -1 on timeout.
    task automatic access(input int k, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [7:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdata, output int lat, output int nlow, output logic err);
        @(negedge clk);
        req_we = we; req_size = sz; req_uns = uns; req_addr = addr; req_wdata = wd;
        req_valid[k] = 1'b1;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        req_we = ~we; req_size = ~sz; req_uns = ~uns; req_addr = ~addr; req_wdata = ~wd;
        lat = -1; nlow = 0; rdata = 'x; err = 1'bx;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (!ready[k]) nlow++;
            if (rvalid[k]) begin
                lat = i; rdata = rdat[k];
`ifdef DMEM_MISALIGN_ERR_EN
                err = rerr[k];
`else
                err = 1'b0;
`endif
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            tests_run++; if (ready[k] !== 1'b1) begin fails++; $display("FAIL reset_ready[%0d] got %b want 1", k, ready[k]); end
            tests_run++; if (rvalid[k] !== 1'b0 || bsy[k] !== 1'b0) begin fails++; $display("FAIL reset_valid_busy[%0d] got %b%b want 00", k, rvalid[k], bsy[k]); end
            tests_run++; if (rdat[k] !== 32'h0) begin fails++; $display("FAIL reset_rdata[%0d] got %h want 0", k, rdat[k]); end
        end
    endtask

    task automatic test_first_load();
        logic [31:0] rd; int lat, nlow; logic err;
        access(0, 1'b0, SZ_WORD, 1'b0, 8'h04, 32'h0, rd, lat, nlow, err);
        tests_run++; if (rd !== 32'd5) begin fails++; $display("FAIL load_w04 got %h want 00000005", rd); end
        tests_run++; if (lat !== 2) begin fails++; $display("FAIL latency_w1 got %0d want 2", lat); end
        tests_run++; if (nlow !== 2) begin fails++; $display("FAIL ready_low_w1 got %0d want 2", nlow); end
        access(0, 1'b0, SZ_WORD, 1'b0, 8'h08, 32'h0, rd, lat, nlow, err);
        tests_run++; if (rd !== 32'd25) begin fails++; $display("FAIL load_w08_init got %h want 00000019", rd); end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; int lat, nlow; logic err;
        logic [7:0]  t_addr [6] = '{8'h13, 8'h11, 8'h12, 8'h10, 8'h10, 8'h10};
        logic [1:0]  t_size [6] = '{SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF, SZ_BYTE, 2'b11};
        logic        t_uns  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] t_exp  [6] = '{32'hFFFFFFDE, 32'h000000BE, 32'hFFFFDEAD, 32'h0000BEEF, 32'hFFFFFFEF, 32'hDEADBEEF};
        access(0, 1'b1, SZ_WORD, 1'b0, 8'h10, 32'hDEADBEEF, rd, lat, nlow, err);
        tests_run++; if (rd !== 32'h0 || lat !== 2) begin fails++; $display("FAIL store_w10 rdata %h lat %0d want 00000000 lat 2", rd, lat); end
        for (int i = 0; i < 6; i++) begin
            access(0, 1'b0, t_size[i], t_uns[i], t_addr[i], 32'h0, rd, lat, nlow, err);
            tests_run++; if (rd !== t_exp[i]) begin fails++; $display("FAIL load_%0d addr %h got %h want %h", i, t_addr[i], rd, t_exp[i]); end
        end
    endtask

    task automatic test_lane_preserve();
        logic [31:0] rd; int lat, nlow; logic err;
        access(0, 1'b1, SZ_WORD, 1'b0, 8'h08, 32'h0, rd, lat, nlow, err);
        access(0, 1'b1, SZ_BYTE, 1'b0, 8'h09, 32'h123456A5, rd, lat, nlow, err);
        access(0, 1'b0, SZ_WORD, 1'b0, 8'h08, 32'h0, rd, lat, nlow, err);
        tests_run++; if (rd !== 32'h0000A500) begin fails++; $display("FAIL byte_store_09 got %h want 0000A500", rd); end
        access(0, 1'b1, SZ_HALF, 1'b0, 8'h0A, 32'hFFFFBEEF, rd, lat, nlow, err);
        access(0, 1'b0, SZ_WORD, 1'b0, 8'h08, 32'h0, rd, lat, nlow, err);
        tests_run++; if (rd !== 32'hBEEFA500) begin fails++; $display("FAIL half_store_0a got %h want BEEFA500", rd); end
    endtask

    task automatic test_back_to_back(input int k);
        int acc[$]; int rsp[$]; logic [31:0] first_rd;
        first_rd = 'x;
        @(negedge clk);
        req_we = 1'b0; req_size = SZ_WORD; req_uns = 1'b0; req_addr = 8'h00; req_wdata = 32'h0;
        req_valid[k] = 1'b1;
        for (int n = 0; n < 14; n++) begin
            if (ready[k]) acc.push_back(n);
            if (rvalid[k]) begin
                if (rsp.size() == 0) first_rd = rdat[k];
                rsp.push_back(n);
            end
            @(negedge clk);
        end
        req_valid[k] = 1'b0;
        tests_run++;
        if (acc.size() < 2 || rsp.size() < 1) begin
            fails++; $display("FAIL b2b_events[w%0d] accepts %0d rsps %0d want >=2 and >=1", WC[k], acc.size(), rsp.size());
        end else begin
            if (acc[1] - acc[0] !== WC[k] + 2) begin fails++; $display("FAIL b2b_spacing[w%0d] got %0d want %0d", WC[k], acc[1] - acc[0], WC[k] + 2); end
            tests_run++; if (rsp[0] - acc[0] !== WC[k] + 1) begin fails++; $display("FAIL b2b_latency[w%0d] got %0d want %0d", WC[k], rsp[0] - acc[0], WC[k] + 1); end
            tests_run++; if (first_rd !== 32'd1) begin fails++; $display("FAIL b2b_rdata[w%0d] got %h want 00000001", WC[k], first_rd); end
        end
        for (int n = 0; n < 10 && bsy[k]; n++) @(negedge clk);
        tests_run++; if (bsy[k] !== 1'b0) begin fails++; $display("FAIL b2b_drain[w%0d] busy got %b want 0", WC[k], bsy[k]); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int lat, nlow; logic err; logic seen;
        @(negedge clk);
        req_we = 1'b1; req_size = SZ_WORD; req_uns = 1'b0; req_addr = 8'h20; req_wdata = 32'hCAFEF00D;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (ready[0] !== 1'b1 || bsy[0] !== 1'b0) begin fails++; $display("FAIL rst_mid_idle ready %b busy %b want 1 0", ready[0], bsy[0]); end
        seen = 1'b0;
        for (int n = 0; n < 4; n++) begin
            if (rvalid[0]) seen = 1'b1;
            @(negedge clk);
        end
        tests_run++; if (seen !== 1'b0) begin fails++; $display("FAIL rst_mid_rsp got rsp_valid 1 want 0"); end
        access(0, 1'b0, SZ_WORD, 1'b0, 8'h20, 32'h0, rd, lat, nlow, err);
        tests_run++; if (rd !== 32'h0) begin fails++; $display("FAIL rst_mid_mem got %h want 00000000", rd); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; int lat, nlow; logic err;
        access(0, 1'b1, SZ_WORD, 1'b0, 8'h05, 32'h11223344, rd, lat, nlow, err);
`ifdef DMEM_MISALIGN_ERR_EN
        tests_run++; if (err !== 1'b1 || rd !== 32'h0 || lat !== 2) begin fails++; $display("FAIL mis_store_rsp err %b rdata %h lat %0d want 1 00000000 2", err, rd, lat); end
        access(0, 1'b0, SZ_WORD, 1'b0, 8'h04, 32'h0, rd, lat, nlow, err);
        tests_run++; if (rd !== 32'd5 || err !== 1'b0) begin fails++; $display("FAIL mis_mem_kept got %h err %b want 00000005 0", rd, err); end
        access(0, 1'b0, SZ_HALF, 1'b1, 8'h07, 32'h0, rd, lat, nlow, err);
        tests_run++; if (rd !== 32'h0 || err !== 1'b1) begin fails++; $display("FAIL mis_half_load got %h err %b want 00000000 1", rd, err); end
`else
        tests_run++; if (rd !== 32'h0 || lat !== 2) begin fails++; $display("FAIL mis_store_rsp rdata %h lat %0d want 00000000 2", rd, lat); end
        access(0, 1'b0, SZ_WORD, 1'b0, 8'h04, 32'h0, rd, lat, nlow, err);
        tests_run++; if (rd !== 32'h11223344) begin fails++; $display("FAIL mis_forced_word got %h want 11223344", rd); end
        access(0, 1'b0, SZ_HALF, 1'b1, 8'h07, 32'h0, rd, lat, nlow, err);
        tests_run++; if (rd !== 32'h00001122) begin fails++; $display("FAIL mis_forced_half got %h want 00001122", rd); end
`endif
    endtask

    initial begin
        test_reset();
        test_first_load();
        test_store_load();
        test_lane_preserve();
        test_back_to_back(1);
        test_back_to_back(2);
        test_reset_mid();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation still running at 200000 want finished");
        $fatal(1, "timeout");
    end

endmodule
